// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
//   Shared definitions for the 1011 sequence-detector slice: the word
//   serializer FSM encoding, the default serializer geometry (also used by
//   the detector's testbench), and a counter-width helper.
// ---------------------------------------------------------------------------
package seq_det_pkg;

  // Serializer FSM: either waiting for a word or shifting one out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Default serializer geometry shared with the detector testbench.
  localparam int SER_WIDTH = 8;
  localparam int SER_DIV   = 1;

  // Width of a counter that runs 0..n-1. A count range of one still needs a
  // one-bit register ($clog2(1) would give zero).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_word_serializer_bit_period_div.sv
// ---------------------------------------------------------------------------
// bit_period_div
//   Divides the clock into bit periods of DIV cycles and flags the first and
//   last cycle of each period. The flags are registered and describe the
//   current cycle.
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   restart       in   a new word loads at this edge: next cycle opens period 0
//   en            in   the current word keeps shifting past this edge
//   period_start  out  current cycle is the first cycle of a bit period
//   period_end    out  current cycle is the last cycle of a bit period
// With neither restart nor en the divider parks at zero with both flags low.
// ---------------------------------------------------------------------------
module bit_period_div
  import seq_det_pkg::*;
#(
  parameter int DIV = SER_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic period_start,
  output logic period_end
);

  localparam int            CW       = cnt_width(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [CW-1:0] div_cnt_r;
  logic [CW-1:0] div_cnt_nxt_s;
  logic          period_start_r;
  logic          period_end_r;

  // Next position inside the bit period; wraps after the last cycle.
  always_comb begin
    div_cnt_nxt_s = CNT_ZERO;
    if (period_end_r) begin
      div_cnt_nxt_s = CNT_ZERO;
    end else begin
      div_cnt_nxt_s = div_cnt_r + CW'(1);
    end
  end

  // Divider count and the registered period flags for the coming cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r      <= CNT_ZERO;
      period_start_r <= 1'b0;
      period_end_r   <= 1'b0;
    end else if (restart) begin
      div_cnt_r      <= CNT_ZERO;
      period_start_r <= 1'b1;
      period_end_r   <= (CNT_LAST == CNT_ZERO);
    end else if (en) begin
      div_cnt_r      <= div_cnt_nxt_s;
      period_start_r <= (div_cnt_nxt_s == CNT_ZERO);
      period_end_r   <= (div_cnt_nxt_s == CNT_LAST);
    end else begin
      div_cnt_r      <= CNT_ZERO;
      period_start_r <= 1'b0;
      period_end_r   <= 1'b0;
    end
  end

  assign period_start = period_start_r;
  assign period_end   = period_end_r;

endmodule

// File: rtl/seq_word_serializer.sv
// ---------------------------------------------------------------------------
// seq_word_serializer
//   Feeds the 1011 sequence detector. Takes parallel words over a valid/ready
//   handshake and shifts them out on x, one bit per DIV-cycle bit period.
//   A one-word pending buffer lets the next word follow the current one with
//   no idle gap, so patterns spanning word boundaries remain visible.
// Parameters
//   WIDTH      bits per word (>= 2)
//   DIV        clocks per bit period (>= 1)
//   MSB_FIRST  1: in_data[WIDTH-1] leaves first; 0: in_data[0] leaves first
//   IDLE_BIT   level of x while no word is being sent
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high reset
//   in_data     in   word to serialize, sampled on the accept edge
//   in_valid    in   in_data is valid
//   in_ready    out  pending buffer empty; accept = in_valid & in_ready
//   x           out  serial bit (registered)
//   bit_strobe  out  first cycle of each bit period
//   word_done   out  last cycle of a word's final bit period
//   busy        out  a word is shifting
// ---------------------------------------------------------------------------
module seq_word_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter int DIV       = SER_DIV,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             bit_strobe,
  output logic             word_done,
  output logic             busy
);

  localparam int             BCW        = cnt_width(WIDTH);
  localparam logic [BCW-1:0] BIT_ZERO   = {BCW{1'b0}};
  localparam logic [BCW-1:0] BIT_PENULT = BCW'(WIDTH - 2);

  // Bit that leaves the shift register first.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Shift register contents after one bit has left.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  ser_state_t       state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [BCW-1:0]   bit_cnt_r;
  logic             final_bit_r;   // current bit is the word's last one
  logic [WIDTH-1:0] pend_data_r;
  logic             pend_valid_r;
  logic             x_r;
  logic             busy_r;

  logic             shifting_s;
  logic             accept_s;
  logic             period_start_s;
  logic             period_end_s;
  logic             word_end_s;
  logic             step_s;
  logic             load_s;
  logic             div_en_s;
  logic [WIDTH-1:0] load_word_s;

  assign shifting_s = (state_r == ST_SHIFT);
  assign accept_s   = in_valid & ~pend_valid_r;

  // Final cycle of the final bit period of the current word.
  assign word_end_s = shifting_s & period_end_s & final_bit_r;
  // A bit period closes but more bits of the word remain.
  assign step_s     = shifting_s & period_end_s & ~final_bit_r;

  // A word enters the shift register at this edge: straight from the
  // handshake when idle, or at a word boundary from pending (if full) or
  // from the handshake (bypassing the empty pending buffer).
  assign load_s   = (~shifting_s & accept_s) |
                    (word_end_s & (pend_valid_r | accept_s));
  assign div_en_s = shifting_s & ~word_end_s;

  // Pending is only ever full while shifting, so it has priority whenever set.
  always_comb begin
    load_word_s = {WIDTH{1'b0}};
    if (pend_valid_r) begin
      load_word_s = pend_data_r;
    end else begin
      load_word_s = in_data;
    end
  end

  bit_period_div #(
    .DIV (DIV)
  ) u_div (
    .clk          (clk),
    .reset        (reset),
    .restart      (load_s),
    .en           (div_en_s),
    .period_start (period_start_s),
    .period_end   (period_end_s)
  );

  // FSM, shift register, bit counter, pending buffer and registered x/busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      x_r          <= IDLE_BIT;
      shreg_r      <= {WIDTH{1'b0}};
      bit_cnt_r    <= BIT_ZERO;
      final_bit_r  <= 1'b0;
      pend_data_r  <= {WIDTH{1'b0}};
      pend_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (word_end_s && !load_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase

      // Shift datapath; x always shows the bit at the head of the register.
      if (load_s) begin
        shreg_r     <= load_word_s;
        bit_cnt_r   <= BIT_ZERO;
        final_bit_r <= 1'b0;
        x_r         <= lead_bit(load_word_s);
      end else if (step_s) begin
        shreg_r     <= advance(shreg_r);
        bit_cnt_r   <= bit_cnt_r + BCW'(1);
        final_bit_r <= (bit_cnt_r == BIT_PENULT);
        x_r         <= lead_bit(advance(shreg_r));
      end else if (word_end_s) begin
        final_bit_r <= 1'b0;
        x_r         <= IDLE_BIT;
      end else begin
        shreg_r     <= shreg_r;
      end

      // Pending buffer: drained at a word boundary, filled mid-word.
      if (word_end_s && pend_valid_r) begin
        pend_valid_r <= 1'b0;
      end else if (shifting_s && !word_end_s && accept_s) begin
        pend_valid_r <= 1'b1;
        pend_data_r  <= in_data;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  assign in_ready   = ~pend_valid_r;
  assign x          = x_r;
  assign busy       = busy_r;
  assign bit_strobe = period_start_s;
  assign word_done  = word_end_s;

endmodule

// File: tb/tb_seq_word_serializer.sv
// Bench for seq_word_serializer: three instances (DIV=1 MSB-first, DIV=3
// MSB-first, DIV=1 LSB-first) checked every cycle against a queue-based model,
// plus literal bit sequences for the directed scenarios.
module tb_seq_word_serializer;

  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic [7:0] in_data    [3];
  logic       in_valid   [3];
  logic       in_ready   [3];
  logic       x          [3];
  logic       bit_strobe [3];
  logic       word_done  [3];
  logic       busy       [3];

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;
  bit rec0    = 1'b0;
  logic trace0 [$];
  int last_wait;

  seq_word_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .x(x[0]), .bit_strobe(bit_strobe[0]),
    .word_done(word_done[0]), .busy(busy[0]));

  seq_word_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_div3 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .x(x[1]), .bit_strobe(bit_strobe[1]),
    .word_done(word_done[1]), .busy(busy[1]));

  seq_word_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .x(x[2]), .bit_strobe(bit_strobe[2]),
    .word_done(word_done[2]), .busy(busy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Each instance: queue of up to two words (head is on the wire), and the
  // cycle index within the head word's WIDTH*DIV-cycle transmission.
  int         qn  [3];
  logic [7:0] qw  [3][2];
  int         pos [3];

  function automatic int div_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic bit msb_of(input int i);
    return (i == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic m_x(input int i);
    logic [7:0] w;
    int bi;
    if (qn[i] == 0) return 1'b0;
    w  = qw[i][0];
    bi = pos[i] / div_of(i);
    return msb_of(i) ? w[7 - bi] : w[bi];
  endfunction

  function automatic logic m_strobe(input int i);
    return (qn[i] > 0) && (pos[i] % div_of(i) == 0);
  endfunction

  function automatic logic m_done(input int i);
    return (qn[i] > 0) && (pos[i] == W * div_of(i) - 1);
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      qn[i]  = 0;
      pos[i] = 0;
    end
    forever begin
      @(posedge clk or posedge reset);
      for (int i = 0; i < 3; i++) begin
        if (reset) begin
          qn[i]  = 0;
          pos[i] = 0;
        end else begin
          bit acc;
          acc = in_valid[i] && (qn[i] < 2);
          if (qn[i] > 0) begin
            if (pos[i] == W * div_of(i) - 1) begin
              qw[i][0] = qw[i][1];
              qn[i]--;
              pos[i] = 0;
            end else begin
              pos[i]++;
            end
          end
          if (acc) begin
            qw[i][qn[i]] = in_data[i];
            qn[i]++;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cmp_en) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("cyc u%0d x", i),          x[i],          m_x(i));
          chk($sformatf("cyc u%0d bit_strobe", i), bit_strobe[i], m_strobe(i));
          chk($sformatf("cyc u%0d word_done", i),  word_done[i],  m_done(i));
          chk($sformatf("cyc u%0d busy", i),       busy[i],       qn[i] > 0);
          chk($sformatf("cyc u%0d in_ready", i),   in_ready[i],   qn[i] < 2);
        end
      end
    end
  end

  // Serial stream of instance 0 while busy.
  initial begin
    forever begin
      @(negedge clk);
      if (rec0 && busy[0] === 1'b1) trace0.push_back(x[0]);
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge with
  // in_valid still high so a following offer continues back-to-back.
  task automatic offer(input int i, input logic [7:0] w);
    int waited;
    waited = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = w;
    while (qn[i] >= 2 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("offer timeout", waited, 0);
    last_wait = waited;
    @(negedge clk);
  endtask

  task automatic wait_idle0(output int cnt);
    cnt = 0;
    while (busy[0] === 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) chk("wait_idle timeout", cnt, 0);
  endtask

  initial begin
    logic [7:0]  v8;
    logic [15:0] v16;
    logic [23:0] v24;
    logic [15:0] ends;
    int cnt;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = 8'h00;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset u%0d x", i),          x[i],          1'b0);
      chk($sformatf("reset u%0d busy", i),       busy[i],       1'b0);
      chk($sformatf("reset u%0d bit_strobe", i), bit_strobe[i], 1'b0);
      chk($sformatf("reset u%0d word_done", i),  word_done[i],  1'b0);
      chk($sformatf("reset u%0d in_ready", i),   in_ready[i],   1'b1);
    end
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 8'hB0, DIV=1, MSB first
    v8 = 8'hB0;
    offer(0, v8);
    in_valid[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1 x bit%0d", k), x[0], v8[7 - k]);
      chk($sformatf("t1 word_done bit%0d", k), word_done[0], k == 7);
      chk($sformatf("t1 strobe bit%0d", k), bit_strobe[0], 1'b1);
      @(negedge clk);
    end
    chk("t1 x idle after", x[0], 1'b0);
    chk("t1 busy after", busy[0], 1'b0);
    repeat (2) @(negedge clk);

    // 2: 8'h0B then 8'hB0 back-to-back
    trace0.delete();
    rec0 = 1'b1;
    offer(0, 8'h0B);
    offer(0, 8'hB0);
    in_valid[0] = 1'b0;
    wait_idle0(cnt);
    rec0 = 1'b0;
    chk("t2 busy run", cnt, 15);
    chk("t2 bit count", trace0.size(), 16);
    v16  = 16'h0BB0;
    ends = 16'h0000;
    if (trace0.size() == 16) begin
      for (int k = 0; k < 16; k++) chk($sformatf("t2 x bit%0d", k), trace0[k], v16[15 - k]);
      for (int k = 3; k < 16; k++)
        if (trace0[k-3] == 1'b1 && trace0[k-2] == 1'b0 && trace0[k-1] == 1'b1 && trace0[k] == 1'b1)
          ends[k] = 1'b1;
    end
    chk("t2 1011 ends", ends, 16'h0880);
    repeat (2) @(negedge clk);

    // 3: DIV=3, 8'hA5
    v8 = 8'hA5;
    offer(1, v8);
    in_valid[1] = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("t3 x c%0d", k), x[1], v8[7 - k / 3]);
      chk($sformatf("t3 strobe c%0d", k), bit_strobe[1], (k % 3) == 0);
      chk($sformatf("t3 word_done c%0d", k), word_done[1], k == 23);
      @(negedge clk);
    end
    chk("t3 busy after", busy[1], 1'b0);
    chk("t3 x after", x[1], 1'b0);

    // 4: LSB first, 8'h0D -> 1,0,1,1,0,0,0,0
    v8 = 8'hB0;
    offer(2, 8'h0D);
    in_valid[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4 x bit%0d", k), x[2], v8[7 - k]);
      @(negedge clk);
    end
    chk("t4 busy after", busy[2], 1'b0);
    repeat (2) @(negedge clk);

    // 5: three words offered consecutively
    trace0.delete();
    rec0 = 1'b1;
    offer(0, 8'h3C);
    offer(0, 8'h5A);
    chk("t5 in_ready low", in_ready[0], 1'b0);
    offer(0, 8'hC3);
    chk("t5 stall cycles", last_wait, 7);
    in_valid[0] = 1'b0;
    wait_idle0(cnt);
    rec0 = 1'b0;
    chk("t5 bit count", trace0.size(), 24);
    v24 = 24'h3C5AC3;
    if (trace0.size() == 24)
      for (int k = 0; k < 24; k++) chk($sformatf("t5 x bit%0d", k), trace0[k], v24[23 - k]);
    repeat (2) @(negedge clk);

    // 6: reset at bit 4 of 8'hFF with a word pending
    offer(0, 8'hFF);
    offer(0, 8'h11);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6 pre-reset busy", busy[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6 x", x[0], 1'b0);
    chk("t6 busy", busy[0], 1'b0);
    chk("t6 in_ready", in_ready[0], 1'b1);
    chk("t6 word_done", word_done[0], 1'b0);
    chk("t6 bit_strobe", bit_strobe[0], 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t6 quiet word_done %0d", k), word_done[0], 1'b0);
      chk($sformatf("t6 quiet busy %0d", k), busy[0], 1'b0);
    end
    v8 = 8'h96;
    offer(0, v8);
    in_valid[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t6 next x bit%0d", k), x[0], v8[7 - k]);
      @(negedge clk);
    end
    chk("t6 next busy after", busy[0], 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
